// File: rtl/fetch_stage_if.sv
// Instruction-cache request/response bus between the fetch stage (master) and the icache (slave).
interface fetch_stage_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;

    modport master (output iREN, iaddr, input ihit, iload);
    modport slave  (input iREN, iaddr, output ihit, iload);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the icache, and feeds {instr, pc+4, valid} to IF/ID.
// Handles EX/MEM redirects (buffered while stalled), hazard stalls, and a permanent halt.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST,
    fetch_stage_if.master    ic,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic             halt,
    output logic [31:0]      instr_out,
    output logic [31:0]      pc_4_out,
    output logic             valid_out,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);
    typedef enum logic {RUN, HALTED} state_t;

    state_t           state, state_nxt;
    logic [31:0]      pc, pc_nxt;
    logic             pend_valid, pend_valid_nxt;
    logic [31:0]      pend_pc, pend_pc_nxt;
    logic [31:0]      instr_nxt, pc_4_nxt;
    logic             valid_nxt;
    logic [CNT_W-1:0] count_nxt;

    logic        advance;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus_4;

    assign advance         = ~stall;
    assign redirect_target = redirect_pc & ~32'h3;
    assign pc_plus_4       = pc + 32'd4;

    assign ic.iaddr = pc;
    assign ic.iREN  = (state == RUN) & ~pend_valid;
    assign halted   = (state == HALTED);

    // NOTE: every next-state variable is defaulted to its current value first, so no
    // path through the case/if tree can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pend_valid_nxt = pend_valid;
        pend_pc_nxt    = pend_pc;
        instr_nxt      = instr_out;
        pc_4_nxt       = pc_4_out;
        valid_nxt      = valid_out;
        count_nxt      = fetch_count;

        case (state)
            RUN: begin
                if (halt) begin
                    state_nxt      = HALTED;
                    pend_valid_nxt = 1'b0;
                    pend_pc_nxt    = 32'h0;
                    if (advance) begin
                        instr_nxt = 32'h0;
                        pc_4_nxt  = 32'h0;
                        valid_nxt = 1'b0;
                    end
                end else if (advance) begin
                    // Default to a bubble; only a real hit overrides it below.
                    instr_nxt = 32'h0;
                    pc_4_nxt  = 32'h0;
                    valid_nxt = 1'b0;
                    if (redirect_valid) begin
                        pc_nxt         = redirect_target;
                        pend_valid_nxt = 1'b0;
                    end else if (pend_valid) begin
                        pc_nxt         = pend_pc;
                        pend_valid_nxt = 1'b0;
                    end else if (ic.ihit) begin
                        instr_nxt = ic.iload;
                        pc_4_nxt  = pc_plus_4;
                        valid_nxt = 1'b1;
                        pc_nxt    = pc_plus_4;
                        count_nxt = fetch_count + CNT_W'(1);
                    end
                end else if (redirect_valid) begin
                    // IF/ID is frozen: remember the newest target until the stall lifts.
                    pend_valid_nxt = 1'b1;
                    pend_pc_nxt    = redirect_target;
                end
            end
            HALTED: begin
                if (advance) begin
                    instr_nxt = 32'h0;
                    pc_4_nxt  = 32'h0;
                    valid_nxt = 1'b0;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= RUN;
            pc          <= PC_INIT;
            pend_valid  <= 1'b0;
            pend_pc     <= 32'h0;
            instr_out   <= 32'h0;
            pc_4_out    <= 32'h0;
            valid_out   <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            pend_valid  <= pend_valid_nxt;
            pend_pc     <= pend_pc_nxt;
            instr_out   <= instr_nxt;
            pc_4_out    <= pc_4_nxt;
            valid_out   <= valid_nxt;
            fetch_count <= count_nxt;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, then random stimulus vs. a queue-based model.
module tb_fetch_stage;
    logic        CLK = 1'b0;
    logic        RST;
    logic        stall, redirect_valid, halt;
    logic [31:0] redirect_pc;
    logic [31:0] instr_out, pc_4_out;
    logic        valid_out, halted;
    logic [31:0] fetch_count;

    fetch_stage_if ic ();

    fetch_stage #(.PC_INIT(32'h0), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .ic(ic.master),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .instr_out(instr_out), .pc_4_out(pc_4_out), .valid_out(valid_out),
        .halted(halted), .fetch_count(fetch_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        bit          rst, ihit, stall, rv, halt;
        logic [31:0] iload, rpc;
        logic [31:0] e_iaddr;
        bit          e_iren, e_valid;
        logic [31:0] e_instr, e_pc4;
        bit          e_halted;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input bit rst, ihit, stl, rv, hlt,
                                input logic [31:0] iload, rpc, e_iaddr, input bit e_iren, e_valid,
                                input logic [31:0] e_instr, e_pc4, input bit e_halted,
                                input logic [31:0] e_cnt);
        vec_t v;
        v.name = name; v.rst = rst; v.ihit = ihit; v.stall = stl; v.rv = rv; v.halt = hlt;
        v.iload = iload; v.rpc = rpc; v.e_iaddr = e_iaddr; v.e_iren = e_iren; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_halted = e_halted; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic drive(input bit rst, ihit, stl, rv, hlt, input logic [31:0] iload, rpc);
        RST = rst; ic.ihit = ihit; stall = stl; redirect_valid = rv; halt = hlt;
        ic.iload = iload; redirect_pc = rpc;
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_iaddr, input bit e_iren,
                             input bit e_valid, input logic [31:0] e_instr, e_pc4,
                             input bit e_halted, input logic [31:0] e_cnt);
        check({tag, ".iaddr"},  ic.iaddr,          e_iaddr);
        check({tag, ".iREN"},   32'(ic.iREN),      32'(e_iren));
        check({tag, ".valid"},  32'(valid_out),    32'(e_valid));
        check({tag, ".instr"},  instr_out,         e_instr);
        check({tag, ".pc_4"},   pc_4_out,          e_pc4);
        check({tag, ".halted"}, 32'(halted),       32'(e_halted));
        check({tag, ".count"},  fetch_count,       e_cnt);
    endtask

    // Reference model: the pending redirect is a queue of at most one target.
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    bit          m_valid, m_halted;
    logic [31:0] m_pend[$];

    function automatic void model_reset();
        m_pc = 32'h0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0; m_halted = 0;
        m_pend.delete();
    endfunction

    function automatic void model_bubble();
        m_instr = 0; m_pc4 = 0; m_valid = 0;
    endfunction

    function automatic void model_step(input bit rst, ihit, stl, rv, hlt,
                                       input logic [31:0] iload, rpc);
        if (rst) model_reset();
        else if (m_halted) begin
            if (!stl) model_bubble();
        end else if (hlt) begin
            m_halted = 1;
            m_pend.delete();
            if (!stl) model_bubble();
        end else if (stl) begin
            if (rv) begin
                m_pend.delete();
                m_pend.push_back(rpc & ~32'h3);
            end
        end else if (rv) begin
            m_pc = rpc & ~32'h3;
            m_pend.delete();
            model_bubble();
        end else if (m_pend.size() != 0) begin
            m_pc = m_pend.pop_front();
            model_bubble();
        end else if (ihit) begin
            m_instr = iload; m_pc4 = m_pc + 4; m_valid = 1;
            m_pc = m_pc + 4; m_cnt = m_cnt + 1;
        end else model_bubble();
    endfunction

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);

        //           name        rst ih st rv ht iload          rpc            iaddr        iren v  instr          pc4          h  cnt
        vecs.push_back(mk("reset",   1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk("seq0",    0, 1, 0, 0, 0, 32'hA000_0000, 32'h0,       32'h4,        1, 1, 32'hA000_0000, 32'h4,       0, 1));
        vecs.push_back(mk("seq1",    0, 1, 0, 0, 0, 32'hA000_0004, 32'h0,       32'h8,        1, 1, 32'hA000_0004, 32'h8,       0, 2));
        vecs.push_back(mk("seq2",    0, 1, 0, 0, 0, 32'hA000_0008, 32'h0,       32'hC,        1, 1, 32'hA000_0008, 32'hC,       0, 3));
        vecs.push_back(mk("seq3",    0, 1, 0, 0, 0, 32'hA000_000C, 32'h0,       32'h10,       1, 1, 32'hA000_000C, 32'h10,      0, 4));
        vecs.push_back(mk("miss0",   0, 0, 0, 0, 0, 32'hDEAD_BEEF, 32'h0,       32'h10,       1, 0, 32'h0,        32'h0,        0, 4));
        vecs.push_back(mk("miss1",   0, 0, 0, 0, 0, 32'hDEAD_BEEF, 32'h0,       32'h10,       1, 0, 32'h0,        32'h0,        0, 4));
        vecs.push_back(mk("miss2",   0, 0, 0, 0, 0, 32'hDEAD_BEEF, 32'h0,       32'h10,       1, 0, 32'h0,        32'h0,        0, 4));
        vecs.push_back(mk("hit10",   0, 1, 0, 0, 0, 32'hA000_0010, 32'h0,       32'h14,       1, 1, 32'hA000_0010, 32'h14,      0, 5));
        vecs.push_back(mk("stall0",  0, 1, 1, 0, 0, 32'hA000_0014, 32'h0,       32'h14,       1, 1, 32'hA000_0010, 32'h14,      0, 5));
        vecs.push_back(mk("stall1",  0, 1, 1, 0, 0, 32'hA000_0014, 32'h0,       32'h14,       1, 1, 32'hA000_0010, 32'h14,      0, 5));
        vecs.push_back(mk("rd_st",   0, 1, 1, 1, 0, 32'hA000_0014, 32'h103,     32'h14,       0, 1, 32'hA000_0010, 32'h14,      0, 5));
        vecs.push_back(mk("rd_go",   0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h100,      1, 0, 32'h0,        32'h0,        0, 5));
        vecs.push_back(mk("hit100",  0, 1, 0, 0, 0, 32'hA000_0100, 32'h0,       32'h104,      1, 1, 32'hA000_0100, 32'h104,     0, 6));
        vecs.push_back(mk("rd2_a",   0, 1, 1, 1, 0, 32'hA000_0104, 32'h103,     32'h104,      0, 1, 32'hA000_0100, 32'h104,     0, 6));
        vecs.push_back(mk("rd2_b",   0, 1, 1, 1, 0, 32'hA000_0104, 32'h200,     32'h104,      0, 1, 32'hA000_0100, 32'h104,     0, 6));
        vecs.push_back(mk("rd2_go",  0, 1, 0, 0, 0, 32'hA000_0104, 32'h0,       32'h200,      1, 0, 32'h0,        32'h0,        0, 6));
        vecs.push_back(mk("to8",     0, 1, 0, 1, 0, 32'hA000_0200, 32'h8,       32'h8,        1, 0, 32'h0,        32'h0,        0, 6));
        vecs.push_back(mk("rd_hit",  0, 1, 0, 1, 0, 32'hA000_0008, 32'h40,      32'h40,       1, 0, 32'h0,        32'h0,        0, 6));
        vecs.push_back(mk("to_top",  0, 1, 0, 1, 0, 32'hA000_0040, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 1, 0, 32'h0,    32'h0,        0, 6));
        vecs.push_back(mk("wrap",    0, 1, 0, 0, 0, 32'h1234_5678, 32'h0,       32'h0,        1, 1, 32'h1234_5678, 32'h0,       0, 7));
        vecs.push_back(mk("halt_st", 0, 1, 1, 1, 1, 32'hA000_0000, 32'h80,      32'h0,        0, 1, 32'h1234_5678, 32'h0,       1, 7));
        vecs.push_back(mk("halted",  0, 1, 0, 1, 0, 32'hA000_0000, 32'h80,      32'h0,        0, 0, 32'h0,        32'h0,        1, 7));
        vecs.push_back(mk("rst_hlt", 1, 1, 1, 1, 1, 32'hA000_0000, 32'h80,      32'h0,        1, 0, 32'h0,        32'h0,        0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].ihit, vecs[i].stall, vecs[i].rv, vecs[i].halt,
                  vecs[i].iload, vecs[i].rpc);
            @(posedge CLK);
            #1;
            check_all(vecs[i].name, vecs[i].e_iaddr, vecs[i].e_iren, vecs[i].e_valid,
                      vecs[i].e_instr, vecs[i].e_pc4, vecs[i].e_halted, vecs[i].e_cnt);
        end

        // Random phase, starting from reset.
        model_reset();
        drive(1, 0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #1;
        for (int c = 0; c < 800; c++) begin
            bit          r_rst, r_ihit, r_stall, r_rv, r_halt;
            logic [31:0] r_iload, r_rpc;
            r_rst   = ($urandom_range(0, 59) == 0);
            r_ihit  = ($urandom_range(0, 3) != 0);
            r_stall = ($urandom_range(0, 3) == 0);
            r_rv    = ($urandom_range(0, 5) == 0);
            r_halt  = ($urandom_range(0, 79) == 0);
            r_iload = $urandom;
            r_rpc   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC | 32'($urandom_range(0, 3))
                                                   : 32'($urandom_range(0, 4095));
            drive(r_rst, r_ihit, r_stall, r_rv, r_halt, r_iload, r_rpc);
            model_step(r_rst, r_ihit, r_stall, r_rv, r_halt, r_iload, r_rpc);
            @(posedge CLK);
            #1;
            check_all($sformatf("rand%0d", c), m_pc, !m_halted && (m_pend.size() == 0),
                      m_valid, m_instr, m_pc4, m_halted, m_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
